// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter feeding one registered output slot from N valid/ready requesters.
// A rotating priority pointer picks the first valid requester at or after the pointer.
// The winner's data is captured into a single-entry slot. The pointer moves past the
// winner only when a transfer actually happens.

// Per-requester lane: flags a valid request that sits at or above the pointer.
// "Above the pointer" is the first half of the rotated search order.
module mux_rr_lane #(
  parameter int PW  = 2,
  parameter int IDX = 0
) (
  input  logic          i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic          o_hi
);
  assign o_hi = i_valid && (PW'(IDX) >= i_ptr);
endmodule

module mux_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  input  logic           out_ready,
  output logic [N-1:0]   grant,
  output logic [PW-1:0]  ptr_o
);

  typedef struct packed {
    logic [W-1:0] data;
    logic [N-1:0] grant;
  } slot_t;

  logic [N-1:0][W-1:0] w_data;
  logic [N-1:0]        w_hi;
  logic [PW-1:0]       w_win;
  logic [PW-1:0]       w_ptr_nxt;
  logic                w_any;
  logic                w_load_en;
  logic                w_xfer;

  slot_t               r_slot;
  logic                r_out_valid;
  logic [PW-1:0]       r_ptr;

  assign w_data = in_data;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_lane
      mux_rr_lane #(.PW(PW), .IDX(g)) u_lane (
        .i_valid (in_valid[g]),
        .i_ptr   (r_ptr),
        .o_hi    (w_hi[g])
      );
    end
  endgenerate

  // Winner select.
  // The lowest-index request at or above the pointer wins. If there is none,
  // the search wraps around and the lowest-index request overall wins.
  always_comb begin
    w_win = '0;
    for (int i = N - 1; i >= 0; i--)
      if (in_valid[i]) w_win = PW'(i);
    for (int i = N - 1; i >= 0; i--)
      if (w_hi[i]) w_win = PW'(i);
  end

  assign w_any     = |in_valid;
  assign w_load_en = !r_out_valid || out_ready;
  assign w_xfer    = w_load_en && w_any;
  assign in_ready  = w_xfer ? (N'(1) << w_win) : '0;
  // Explicit wrap so non-power-of-two N never reaches pointer values >= N.
  assign w_ptr_nxt = (w_win == PW'(N - 1)) ? '0 : w_win + PW'(1);

  // Output slot and pointer.
  // Load on transfer, empty when drained with no request, hold on stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot      <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= '0;
    end else if (w_xfer) begin
      r_slot.data  <= w_data[w_win];
      r_slot.grant <= N'(1) << w_win;
      r_out_valid  <= 1'b1;
      r_ptr        <= w_ptr_nxt;
    end else if (w_load_en) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_slot.data;
  assign grant     = r_slot.grant;
  assign ptr_o     = r_ptr;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int PW = 2;

  typedef struct {
    logic [W-1:0] data;
    logic [N-1:0] grant;
    int           ptr;
  } exp_t;

  logic           clk = 0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [N-1:0]   grant;
  logic [PW-1:0]  ptr_o;

  // second instance, N=3, for the non-power-of-two wrap
  logic        rst3;
  logic [2:0]  v3;
  logic [23:0] d3;
  logic [2:0]  rdy3;
  logic        ov3;
  logic [7:0]  od3;
  logic        or3;
  logic [2:0]  g3;
  logic [1:0]  p3;

  int n_chk = 0, n_pass = 0;
  exp_t sb[$];
  int m_ptr;
  bit m_valid;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .grant(grant), .ptr_o(ptr_o));

  mux_rr_arbiter #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst(rst3), .in_valid(v3), .in_data(d3), .in_ready(rdy3),
    .out_valid(ov3), .out_data(od3), .out_ready(or3),
    .grant(g3), .ptr_o(p3));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // reference: first valid index in rotated order ptr, ptr+1, ... mod N
  function automatic int m_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // one cycle of stimulus; checks handshake and pushes the expected slot item
  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic ordy);
    bit ld;
    int w;
    logic [N-1:0] er;
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = ordy;
    #1;
    ld = !m_valid || ordy;
    w  = m_pick(v, m_ptr);
    er = (ld && w >= 0) ? N'(1 << w) : '0;
    chk("in_ready", 64'(in_ready), 64'(er));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("ptr_o", 64'(ptr_o), 64'(m_ptr));
    if (ld) begin
      if (w >= 0) begin
        sb.push_back('{data: d[w*W +: W], grant: N'(1 << w), ptr: (w + 1) % N});
        m_valid = 1;
        m_ptr = (w + 1) % N;
      end else m_valid = 0;
    end
  endtask

  // asynchronous reset in mid-cycle, checked before any clock edge
  task automatic do_reset();
    @(negedge clk);
    #2;
    in_valid = '0; out_ready = 0; rst = 0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data", 64'(out_data), 0);
    chk("rst_grant", 64'(grant), 0);
    chk("rst_ptr", 64'(ptr_o), 0);
    sb.delete(); m_valid = 0; m_ptr = 0;
    @(negedge clk);
    rst = 1;
  endtask

  // monitor: an item is consumed at the next edge when out_valid && out_ready
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst && out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_unexpected_item", 64'(out_data), 64'hx);
        else begin
          e = sb.pop_front();
          chk("out_data", 64'(out_data), 64'(e.data));
          chk("grant", 64'(grant), 64'(e.grant));
          chk("item_ptr", 64'(ptr_o), 64'(e.ptr));
        end
      end
    end
  end

  initial begin
    logic [N*W-1:0] d;
    rst = 0; in_valid = '0; in_data = '0; out_ready = 0;
    rst3 = 0; v3 = '0; d3 = '0; or3 = 0;
    m_valid = 0; m_ptr = 0;
    repeat (2) @(negedge clk);
    rst = 1; rst3 = 1;

    // single requester 2, back-to-back
    step(4'b0100, {8'h0, 8'hA1, 16'h0}, 1);
    step(4'b0100, {8'h0, 8'hA2, 16'h0}, 1);
    step(4'b0000, '0, 1);
    chk("single_ptr", 64'(ptr_o), 3);

    // all requesting: 10,11,12,13,10
    do_reset();
    repeat (5) step(4'b1111, {8'h13, 8'h12, 8'h11, 8'h10}, 1);
    step(4'b0000, '0, 1);

    // backpressure: slot holds 0x11 for 3 cycles, then drain+load same cycle
    do_reset();
    step(4'b1111, {8'h13, 8'h12, 8'h11, 8'h10}, 1);
    step(4'b1111, {8'h13, 8'h12, 8'h11, 8'h10}, 1);
    repeat (3) step(4'b1111, {8'h13, 8'h12, 8'h11, 8'h10}, 0);
    chk("bp_data", 64'(out_data), 64'h11);
    chk("bp_grant", 64'(grant), 64'b0010);
    step(4'b1111, {8'h13, 8'h12, 8'h11, 8'h10}, 1);
    step(4'b0000, '0, 1);

    // pointer skip: ptr=1, only 3 and 0 valid
    do_reset();
    step(4'b0001, {24'h0, 8'h55}, 1);
    step(4'b1001, {8'hB3, 16'h0, 8'hB0}, 1);
    step(4'b1001, {8'hB3, 16'h0, 8'hB0}, 1);
    step(4'b0000, '0, 1);
    chk("skip_ptr", 64'(ptr_o), 1);

    // randomized traffic with backpressure and occasional mid-stall resets
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else begin
        d = {$urandom, $urandom};
        step(N'($urandom), d, ($urandom_range(0, 3) != 0));
      end
    end
    repeat (3) step('0, '0, 1);
    chk("sb_empty", 64'(sb.size()), 0);

    // N=3: ptr wraps 2->0, then reset while stalled
    @(negedge clk); v3 = 3'b100; d3 = {8'hC2, 8'hC1, 8'hC0}; or3 = 1;
    #1; chk("n3_ready2", 64'(rdy3), 64'b100);
    @(negedge clk); v3 = 3'b011; or3 = 0;
    #1;
    chk("n3_grant", 64'(g3), 64'b100);
    chk("n3_wrap", 64'(p3), 0);
    chk("n3_data", 64'(od3), 64'hC2);
    @(negedge clk);
    #1;
    chk("n3_stall_valid", 64'(ov3), 1);
    chk("n3_stall_ready", 64'(rdy3), 0);
    #1; rst3 = 0;
    #1;
    chk("n3_rst_valid", 64'(ov3), 0);
    chk("n3_rst_ptr", 64'(p3), 0);
    @(negedge clk); rst3 = 1; or3 = 1;
    #1; chk("n3_after_rst_ready", 64'(rdy3), 64'b001);
    @(negedge clk);
    #1;
    chk("n3_after_rst_grant", 64'(g3), 64'b001);
    chk("n3_after_rst_data", 64'(od3), 64'hC0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
Round-robin arbiter that shares one W-bit output channel among N requesters, each using a valid/ready handshake. It selects one requester per cycle and loads that requester's data into a single-entry registered output slot. The block sits between multiple producers and a single consumer. It is the sequencing layer around a wide select mux, in the same family as the team's mux-built gates.

Parameters:
N, 4, number of requesters (N >= 2, need not be a power of two)
W, 8, data width in bits

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
in_valid  input  N  per-requester valid; bit i belongs to requester i
in_data  input  N*W  requester i data occupies bits [i*W +: W]
in_ready  output  N  per-requester accept; at most one bit set
out_valid  output  1  output slot holds a valid item
out_data  output  W  output slot data
out_ready  input  1  consumer accepts the item when out_valid is also 1
grant  output  N  one-hot index of the requester that loaded the current slot; registered
ptr_o  output  clog2(N)  current round-robin priority pointer, for debug and verification

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0, out_data=0, grant=0, ptr=0.
  - Takes effect immediately; does not wait for a clock edge.
- Load condition: load_en = !out_valid || out_ready. This means the slot is empty or is being drained in the same cycle.
- Selection (combinational):
  - Search indices ptr, ptr+1, ... ptr+N-1 modulo N.
  - The winner is the first index i with in_valid[i]=1.
  - in_ready[i]=1 only when load_en=1 and i is the winner; all other bits are 0.
  - When load_en=0, in_ready is all 0.
- Transfer: requester i hands off on any cycle with in_valid[i] && in_ready[i].
- On the clock edge, when a transfer from winner i occurs:
  - out_data <= in_data[i]
  - out_valid <= 1
  - grant <= one-hot(i)
  - ptr <= (i==N-1) ? 0 : i+1
- On the clock edge, when load_en=1 and no in_valid bit is set:
  - out_valid <= 0
  - out_data, grant and ptr hold their values.
- On the clock edge, when load_en=0 (stall):
  - All registers hold.
  - out_data and grant must stay stable while out_valid=1 and out_ready=0.
- Drain and load in the same cycle: allowed. This gives full throughput of one item per cycle with no bubble.
- Latency: 1 cycle from an input transfer to out_valid and the data appearing.
- Fairness: the pointer advances only on a transfer. A requester that holds in_valid high is served within N transfers.
- Combinational dependency: in_ready depends on in_valid and out_ready. Producers must not make in_valid depend on in_ready, so no combinational loop forms.
- Reset during a stall: the held item is dropped, out_valid=0, and the next grant search starts at requester 0.
- Pointer wrap: the pointer wraps from N-1 to 0 for any N, including N that is not a power of two. Pointer values >= N are unreachable.

Test Plan:
- Reset check: drive rst=0 mid-simulation with no clock edge -> out_valid=0, out_data=0, grant=0 and ptr_o=0 immediately.
- Single requester: N=4, requester 2 sends 0xA1 then 0xA2 back-to-back, out_ready=1 -> out_data is 0xA1 then 0xA2 on consecutive cycles, grant=4'b0100 both times, ptr_o=3.
- All requesting: in_data = 0x10, 0x11, 0x12, 0x13, all in_valid=1, out_ready=1 -> output sequence 0x10, 0x11, 0x12, 0x13, 0x10; exactly one in_ready bit set per cycle.
- Backpressure: slot holds 0x11, out_ready=0 for 3 cycles -> in_ready=0000, out_data=0x11 and grant=0010 stable; on release, the next item is loaded in the same cycle.
- Pointer skip: ptr_o=1 and only requesters 3 and 0 valid -> requester 3 is served first, then 0; ptr_o goes to 0 and then 1.
- N=3 wrap and reset mid-stall: with N=3, ptr_o goes 2->0 after requester 2 is served. Assert rst=0 while stalled with out_valid=1 -> item dropped; after release, with requesters 0 and 1 valid, requester 0 is granted first.
